// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
//
// The result is computed from A/B at the start edge and parked in pending
// registers. HI/LO are updated only when the busy countdown expires, which
// models a fixed-latency iterative unit while keeping the operand capture
// simple.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset
//   start  in   1   launch mdop this cycle (ignored while busy)
//   mdop   in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   A      in  32   rs operand
//   B      in  32   rt operand
//   busy   out  1   multiply/divide in flight (registered)
//   HI     out 32   HI register
//   LO     out 32   LO register

module mdu #(
    // Both must lie in 1..15 to fit the 4-bit countdown.
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
    localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    // ------------------------------------------------------------------
    // Datapath: full 64-bit products and sign-corrected divide
    // ------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] a_mag, b_mag;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot, rem;

    // Sign-extending to 64 bits makes the low 64 bits of the product the
    // two's-complement signed result.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    assign div_signed = (mdop == 3'd2);
    assign a_mag = (div_signed && A[31]) ? (32'd0 - A) : A;
    assign b_mag = (div_signed && B[31]) ? (32'd0 - B) : B;

    // Guarded so a zero divisor never produces X; the result is discarded.
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, signs agree.
    assign quot = (div_signed && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
    assign rem  = (div_signed && A[31]) ? (32'd0 - r_mag) : r_mag;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (mdop)
                        3'd0: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MultCnt;
                            state_d   = StBusy;
                        end
                        3'd1: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MultCnt;
                            state_d   = StBusy;
                        end
                        3'd2, 3'd3: begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            // Divide by zero still occupies the unit but
                            // leaves HI/LO untouched.
                            pend_wr_d = (B != 32'd0);
                            cnt_d     = DivCnt;
                            state_d   = StBusy;
                        end
                        3'd4:    hi_d = A;
                        3'd5:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                // <= 1 rather than == 1 so a corrupted zero count cannot lock up.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    pend_wr_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = (state_q == StBusy);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
